// File: rtl/lc_1252_odd_counter_if.sv
// Bundle for the odd-cell scanner: scan request, memory read port and result stream.
// The slave modport is the scanner's view; the master modport is the environment's.
interface lc_1252_odd_counter_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int CNT_WIDTH  = ADDR_WIDTH + 1
);
  logic                  start;
  logic [7:0]            m;
  logic [7:0]            n;
  logic                  busy;
  logic                  mem_en;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_rd_data;
  logic [CNT_WIDTH-1:0]  odd_cells;
  logic                  out_err;
  logic                  out_tvalid;
  logic                  out_tready;

  modport slave (
    input  start, m, n, mem_rd_data, out_tready,
    output busy, mem_en, mem_addr, odd_cells, out_err, out_tvalid
  );

  modport master (
    output start, m, n, mem_rd_data, out_tready,
    input  busy, mem_en, mem_addr, odd_cells, out_err, out_tvalid
  );
endinterface

// File: rtl/lc_1252_odd_counter.sv
// Scans the row-major matrix memory cell by cell and counts odd-valued cells,
// returning the total on a valid/ready result port.
module lc_1252_odd_counter #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int CNT_WIDTH  = ADDR_WIDTH + 1
) (
  input logic clk,
  input logic rst,
  lc_1252_odd_counter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

  localparam logic [16:0] MAX_CELLS = 17'(2 ** ADDR_WIDTH);

  state_t                state_reg, state_next;
  logic [ADDR_WIDTH-1:0] scan_cnt_reg;
  logic [ADDR_WIDTH-1:0] t_last_reg;
  logic [CNT_WIDTH-1:0]  acc_reg;
  logic [CNT_WIDTH-1:0]  odd_cells_reg;
  logic                  out_err_reg;
  logic                  rd_vld_reg;
  logic [15:0]           prod;
  logic                  dim_bad;
  logic                  last_issue;
  logic                  unused_rd_bits;

  assign prod       = 16'(bus.m) * 16'(bus.n);
  assign dim_bad    = (prod == 16'd0) || ({1'b0, prod} > MAX_CELLS);
  assign last_issue = (scan_cnt_reg == t_last_reg);
  // Only the LSB decides parity; the upper data bits are deliberately ignored.
  assign unused_rd_bits = ^bus.mem_rd_data[DATA_WIDTH-1:1];

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (bus.start) state_next = dim_bad ? DONE : SCAN;
      SCAN:    if (last_issue) state_next = DRAIN;
      // Stay until the final read's data has been folded into acc_reg.
      DRAIN:   if (!rd_vld_reg) state_next = DONE;
      DONE:    if (bus.out_tready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      scan_cnt_reg  <= '0;
      t_last_reg    <= '0;
      acc_reg       <= '0;
      odd_cells_reg <= '0;
      out_err_reg   <= 1'b0;
      rd_vld_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      rd_vld_reg <= (state_reg == SCAN);
      if (rd_vld_reg) acc_reg <= acc_reg + CNT_WIDTH'(bus.mem_rd_data[0]);
      case (state_reg)
        IDLE: if (bus.start) begin
          scan_cnt_reg  <= '0;
          acc_reg       <= '0;
          odd_cells_reg <= '0;
          out_err_reg   <= dim_bad;
          t_last_reg    <= ADDR_WIDTH'(prod - 16'd1);
        end
        SCAN:  scan_cnt_reg <= scan_cnt_reg + 1'b1;
        DRAIN: if (!rd_vld_reg) odd_cells_reg <= acc_reg;
        DONE:  if (bus.out_tready) out_err_reg <= 1'b0;
        default: ;
      endcase
    end
  end

  assign bus.busy       = (state_reg != IDLE);
  assign bus.mem_en     = (state_reg == SCAN);
  assign bus.mem_addr   = (state_reg == SCAN) ? scan_cnt_reg : '0;
  assign bus.odd_cells  = odd_cells_reg;
  assign bus.out_err    = out_err_reg;
  assign bus.out_tvalid = (state_reg == DONE);
endmodule

// File: tb/tb_lc_1252_odd_counter.sv
// Self-checking bench for lc_1252_odd_counter: vector table, hand-written corner
// sequences and randomized scans against a behavioural odd-cell model.
module tb_lc_1252_odd_counter;
  localparam int DW = 8;
  localparam int AW = 8;
  localparam int CW = AW + 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  lc_1252_odd_counter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) bus ();
  lc_1252_odd_counter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Registered-read memory plus a read monitor checking in-order, gap-free addresses.
  logic [7:0] mem [0:255];
  logic [7:0] rd_data;
  int read_total = 0;
  int addr_bad   = 0;
  int exp_addr   = 0;
  assign bus.mem_rd_data = rd_data;

  always @(posedge clk) begin
    if (bus.mem_en) begin
      rd_data <= mem[bus.mem_addr];
      if (int'(bus.mem_addr) != exp_addr) addr_bad++;
      exp_addr = int'(bus.mem_addr) + 1;
      read_total++;
    end else begin
      exp_addr = 0;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic fill(input int mode);
    for (int i = 0; i < 256; i++) begin
      case (mode)
        0: begin
          logic [7:0] pat [0:5];
          pat = '{8'd1, 8'd3, 8'd1, 8'd1, 8'd3, 8'd1};
          mem[i] = (i < 6) ? pat[i] : 8'd0;
        end
        1: mem[i] = 8'd2;
        2: mem[i] = 8'($urandom_range(0, 127) * 2 + 1);
        3: mem[i] = (i == 0) ? 8'd7 : 8'd0;
        default: mem[i] = 8'($urandom);
      endcase
    end
  endtask

  // Reference: count odd values among the first m*n cells, or flag bad dimensions.
  task automatic model(input int mm, input int nn, output int cnt, output int err);
    int t;
    t = mm * nn;
    cnt = 0;
    err = (t == 0 || t > 256) ? 1 : 0;
    if (err == 0)
      for (int i = 0; i < t; i++) cnt += (int'(mem[i]) % 2);
  endtask

  task automatic run(input int mm, input int nn, input int hold, input string tag,
                     output int got_cnt, output int got_err);
    int r0, b0, lat, ecnt, eerr, t, stable;
    r0 = read_total;
    b0 = addr_bad;
    bus.m = 8'(mm);
    bus.n = 8'(nn);
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    lat = 0;
    while (!bus.out_tvalid && lat < 1000) begin
      @(posedge clk);
      #1 lat++;
    end
    model(mm, nn, ecnt, eerr);
    t = mm * nn;
    got_cnt = int'(bus.odd_cells);
    got_err = int'(bus.out_err);
    chk({tag, "_valid"}, int'(bus.out_tvalid), 1);
    chk({tag, "_cnt"}, got_cnt, ecnt);
    chk({tag, "_err"}, got_err, eerr);
    chk({tag, "_reads"}, read_total - r0, (eerr != 0) ? 0 : t);
    chk({tag, "_addr"}, addr_bad - b0, 0);
    if (eerr == 0) chk({tag, "_latency"}, lat, t + 2);
    stable = 1;
    for (int k = 0; k < hold; k++) begin
      @(posedge clk);
      #1;
      if (!bus.out_tvalid || int'(bus.odd_cells) != got_cnt || int'(bus.out_err) != got_err
          || read_total != r0 + ((eerr != 0) ? 0 : t))
        stable = 0;
    end
    if (hold > 0) chk({tag, "_hold"}, stable, 1);
    bus.out_tready = 1'b1;
    @(posedge clk);
    #1 bus.out_tready = 1'b0;
    chk({tag, "_post_valid"}, int'(bus.out_tvalid), 0);
    chk({tag, "_post_busy"}, int'(bus.busy), 0);
    chk({tag, "_post_err"}, int'(bus.out_err), 0);
    $display("txn %s m=%0d n=%0d odd=%0d err=%0d lat=%0d hold=%0d", tag, mm, nn,
             got_cnt, got_err, lat, hold);
  endtask

  typedef struct {
    int m;
    int n;
    int mode;
    int hold;
    int exp_cnt;
    int exp_err;
  } vec_t;

  vec_t vecs [0:8];

  initial begin
    int gc, ge, lat, r0, quiet;
    vecs[0] = '{2, 3, 0, 0, 6, 0};
    vecs[1] = '{2, 2, 1, 0, 0, 0};
    vecs[2] = '{16, 16, 2, 0, 256, 0};
    vecs[3] = '{0, 5, 2, 0, 0, 1};
    vecs[4] = '{2, 3, 0, 10, 6, 0};
    vecs[5] = '{1, 1, 3, 0, 1, 0};
    vecs[6] = '{17, 16, 2, 0, 0, 1};
    vecs[7] = '{8, 32, 2, 0, 256, 0};
    vecs[8] = '{5, 0, 2, 0, 0, 1};

    rst = 1'b1;
    bus.start = 1'b0;
    bus.m = '0;
    bus.n = '0;
    bus.out_tready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", int'({bus.busy, bus.mem_en, bus.mem_addr, bus.odd_cells,
                              bus.out_err, bus.out_tvalid}), 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int v = 0; v < 9; v++) begin
      fill(vecs[v].mode);
      run(vecs[v].m, vecs[v].n, vecs[v].hold, $sformatf("vec%0d", v), gc, ge);
      chk($sformatf("vec%0d_table_cnt", v), gc, vecs[v].exp_cnt);
      chk($sformatf("vec%0d_table_err", v), ge, vecs[v].exp_err);
    end

    // A second start during SCAN must be ignored.
    fill(0);
    r0 = read_total;
    bus.m = 8'd2;
    bus.n = 8'd3;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    lat = 0;
    repeat (2) begin
      @(posedge clk);
      #1 lat++;
    end
    bus.m = 8'd4;
    bus.n = 8'd4;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    lat++;
    while (!bus.out_tvalid && lat < 1000) begin
      @(posedge clk);
      #1 lat++;
    end
    chk("midstart_cnt", int'(bus.odd_cells), 6);
    chk("midstart_latency", lat, 8);
    chk("midstart_reads", read_total - r0, 6);
    $display("txn midstart m=2 n=3 odd=%0d lat=%0d", bus.odd_cells, lat);
    bus.out_tready = 1'b1;
    @(posedge clk);
    #1 bus.out_tready = 1'b0;
    chk("midstart_post_busy", int'(bus.busy), 0);

    // Reset in the middle of a scan aborts it without any result.
    fill(2);
    bus.m = 8'd16;
    bus.n = 8'd16;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    chk("midrst_busy_before", int'(bus.busy), 1);
    @(posedge clk);
    #1;
    chk("midrst_outputs", int'({bus.busy, bus.mem_en, bus.mem_addr, bus.odd_cells,
                               bus.out_err, bus.out_tvalid}), 0);
    rst = 1'b0;
    quiet = 1;
    repeat (300) begin
      @(posedge clk);
      #1;
      if (bus.out_tvalid || bus.busy) quiet = 0;
    end
    chk("midrst_no_result", quiet, 1);
    $display("txn midrst aborted 16x16 scan");

    // out_tready held high: one-cycle valid, immediate restart.
    fill(3);
    bus.out_tready = 1'b1;
    bus.m = 8'd1;
    bus.n = 8'd1;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    lat = 0;
    while (!bus.out_tvalid && lat < 1000) begin
      @(posedge clk);
      #1 lat++;
    end
    chk("ready_hi_cnt", int'(bus.odd_cells), 1);
    chk("ready_hi_latency", lat, 3);
    @(posedge clk);
    #1;
    chk("ready_hi_one_cycle", int'(bus.out_tvalid), 0);
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    chk("ready_hi_restart_busy", int'(bus.busy), 1);
    lat = 0;
    while (!bus.out_tvalid && lat < 1000) begin
      @(posedge clk);
      #1 lat++;
    end
    chk("ready_hi_restart_cnt", int'(bus.odd_cells), 1);
    $display("txn ready_hi m=1 n=1 odd=%0d", bus.odd_cells);
    @(posedge clk);
    #1 bus.out_tready = 1'b0;

    // Randomized dimensions and contents against the reference model.
    for (int r = 0; r < 25; r++) begin
      fill(4);
      run(int'($urandom_range(0, 18)), int'($urandom_range(0, 18)),
          int'($urandom_range(0, 3)), $sformatf("rand%0d", r), gc, ge);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
